// File: rtl/parity_rx_checker.sv
// parity_rx_checker: serial frame receiver with even-parity and stop-bit checking.
// Frame on the line: start(0), WIDTH data bits LSB first, even parity, stop(1).
// Every state change is qualified by sin_valid, so the sender may stall anywhere.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for a start bit (0) on a valid edge
// S_DATA   | shifting in data bits, r_cnt = index of the next bit
// S_PARITY | sampling the parity bit, capturing the mismatch flag
// S_STOP   | sampling the stop bit, publishing the completed frame
module parity_rx_checker #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sin_valid,
  input  logic             sin_bit,
  output logic [WIDTH-1:0] data_out,
  output logic             frame_done,
  output logic             parity_err,
  output logic             frame_err,
  output logic             busy
);

  // One extra bit so the counter can reach WIDTH without wrapping.
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_shift;
  logic             r_par;
  logic             r_par_flag;
  logic [WIDTH-1:0] r_data;
  logic             r_done;
  logic             r_perr;
  logic             r_ferr;
  logic             w_last;

  assign w_last = (r_cnt == CW'(WIDTH - 1));

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode; nothing moves on edges without sin_valid.
  always_comb begin
    w_next = r_state;
    if (sin_valid) begin
      case (r_state)
        S_IDLE:   if (!sin_bit) w_next = S_DATA;
        S_DATA:   if (w_last) w_next = S_PARITY;
        S_PARITY: w_next = S_STOP;
        S_STOP:   w_next = S_IDLE;
        default:  w_next = S_IDLE;
      endcase
    end
  end

  // Datapath: bit counter, shift register, running parity and result registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt      <= '0;
      r_shift    <= '0;
      r_par      <= 1'b0;
      r_par_flag <= 1'b0;
      r_data     <= '0;
      r_done     <= 1'b0;
      r_perr     <= 1'b0;
      r_ferr     <= 1'b0;
    end else begin
      // The done pulse lasts one cycle whatever sin_valid does next.
      r_done <= 1'b0;
      if (sin_valid) begin
        case (r_state)
          S_IDLE: begin
            if (!sin_bit) begin
              r_cnt <= '0;
              r_par <= 1'b0;
            end
          end
          S_DATA: begin
            for (int i = 0; i < WIDTH; i++) begin
              if (r_cnt == CW'(i)) r_shift[i] <= sin_bit;
            end
            r_par <= r_par ^ sin_bit;
            r_cnt <= r_cnt + CW'(1);
          end
          S_PARITY: begin
            r_par_flag <= r_par ^ sin_bit;
          end
          S_STOP: begin
            // A bad stop bit still publishes the word; both flags are independent.
            r_data <= r_shift;
            r_perr <= r_par_flag;
            r_ferr <= ~sin_bit;
            r_done <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign data_out   = r_data;
  assign frame_done = r_done;
  assign parity_err = r_perr;
  assign frame_err  = r_ferr;
  assign busy       = (r_state != S_IDLE);

endmodule
